// File: rtl/i4004_fetch_if.sv
// MCS-4 fetch bus bundle: ROM dbus, bus timing, execute-stage hooks and the assembled instruction.
// The breakpoint signals exist only when MCS4_FETCH_BKPT_EN is defined.
interface i4004_fetch_if;
  // Handshake: instr_valid is a one-cycle push with no ready (execute must accept it);
  // instr_* hold until the next pulse. jmp_valid/jmp_addr are sampled only in X3.
  logic        sync;
  logic [2:0]  icyc;
  logic        cm_rom;
  logic [3:0]  dbus_out;
  logic [3:0]  dbus_in;
  logic        x2_oe;
  logic [3:0]  x2_data;
  logic        x2_cm;
  logic        jmp_valid;
  logic [11:0] jmp_addr;
  logic        instr_valid;
  logic [3:0]  instr_opr;
  logic [3:0]  instr_opa;
  logic [7:0]  instr_word2;
  logic        instr_two;
  logic [11:0] instr_pc;
  logic        fetch_state;
`ifdef MCS4_FETCH_BKPT_EN
  logic        bkpt_en;
  logic [11:0] bkpt_addr;
  logic        bkpt_resume;
  logic        bkpt_hit;
`endif

  modport master (
    output sync, icyc, cm_rom, dbus_out, instr_valid, instr_opr, instr_opa,
           instr_word2, instr_two, instr_pc, fetch_state,
`ifdef MCS4_FETCH_BKPT_EN
    output bkpt_hit,
    input  bkpt_en, bkpt_addr, bkpt_resume,
`endif
    input  dbus_in, x2_oe, x2_data, x2_cm, jmp_valid, jmp_addr
  );

  modport slave (
    input  sync, icyc, cm_rom, dbus_out, instr_valid, instr_opr, instr_opa,
           instr_word2, instr_two, instr_pc, fetch_state,
`ifdef MCS4_FETCH_BKPT_EN
    input  bkpt_hit,
    output bkpt_en, bkpt_addr, bkpt_resume,
`endif
    output dbus_in, x2_oe, x2_data, x2_cm, jmp_valid, jmp_addr
  );
endinterface

// File: rtl/i4004_fetch.sv
// i4004 instruction-fetch / bus-timing master: 8-phase cycle, PC out on A1..A3, OPR/OPA in at M1/M2.
// Optional breakpoint unit enabled by defining MCS4_FETCH_BKPT_EN.
module i4004_fetch #(
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [3:0]  DBUS_IDLE = 4'h0
) (
  input logic           clk,
  input logic           rst_n,
  i4004_fetch_if.master bus
);
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;
  typedef enum logic {WORD1, WORD2} fetch_state_t;

  phase_t       phase;
  fetch_state_t state;
  logic [11:0]  pc, w1_pc, next_pc, instr_pc;
  logic [3:0]   opr_q, w1_opr, w1_opa, instr_opr, instr_opa, dbus;
  logic [7:0]   instr_word2;
  logic         instr_two, instr_valid, boot, fetch_en;

`ifdef MCS4_FETCH_BKPT_EN
  logic halted, resume_q;
  assign fetch_en     = !halted;
  assign bus.bkpt_hit = halted;
`else
  assign fetch_en = 1'b1;
`endif

  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == 4'h1) || (opr == 4'h2 && !opa[0]) || (opr == 4'h4) ||
           (opr == 4'h5) || (opr == 4'h7);
  endfunction

  assign next_pc = bus.jmp_valid ? bus.jmp_addr : pc + 12'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= X3;
      state       <= WORD1;
      pc          <= RESET_PC;
      boot        <= 1'b1;
      opr_q       <= 4'h0;
      w1_opr      <= 4'h0;
      w1_opa      <= 4'h0;
      w1_pc       <= 12'h000;
      instr_valid <= 1'b0;
      instr_opr   <= 4'h0;
      instr_opa   <= 4'h0;
      instr_word2 <= 8'h00;
      instr_two   <= 1'b0;
      instr_pc    <= 12'h000;
`ifdef MCS4_FETCH_BKPT_EN
      halted      <= 1'b0;
      resume_q    <= 1'b0;
`endif
    end else begin
      phase       <= phase_t'(phase + 3'd1);
      instr_valid <= 1'b0;
      if (phase == M1 && fetch_en) opr_q <= bus.dbus_in;
      // The M2 edge completes the word, so the result is visible during X1.
      if (phase == M2 && fetch_en) begin
        if (state == WORD2) begin
          instr_valid <= 1'b1;
          instr_opr   <= w1_opr;
          instr_opa   <= w1_opa;
          instr_word2 <= {opr_q, bus.dbus_in};
          instr_two   <= 1'b1;
          instr_pc    <= w1_pc;
          state       <= WORD1;
        end else if (is_two_word(opr_q, bus.dbus_in)) begin
          w1_opr <= opr_q;
          w1_opa <= bus.dbus_in;
          w1_pc  <= pc;
          state  <= WORD2;
        end else begin
          instr_valid <= 1'b1;
          instr_opr   <= opr_q;
          instr_opa   <= bus.dbus_in;
          instr_word2 <= 8'h00;
          instr_two   <= 1'b0;
          instr_pc    <= pc;
        end
      end
`ifdef MCS4_FETCH_BKPT_EN
      if (halted && bus.bkpt_resume) resume_q <= 1'b1;
`endif
      // The X3 that leaves reset only starts the cycle; RESET_PC is fetched first.
      if (phase == X3) begin
        if (boot) begin
          boot <= 1'b0;
`ifdef MCS4_FETCH_BKPT_EN
        end else if (halted) begin
          if (resume_q || bus.bkpt_resume) begin
            halted   <= 1'b0;
            resume_q <= 1'b0;
          end
`endif
        end else begin
          pc <= next_pc;
          if (bus.jmp_valid) state <= WORD1;
`ifdef MCS4_FETCH_BKPT_EN
          if (bus.bkpt_en && next_pc == bus.bkpt_addr) halted <= 1'b1;
`endif
        end
      end
    end
  end

  always_comb begin
    dbus = DBUS_IDLE;
    case (phase)
      A1:      if (fetch_en) dbus = pc[3:0];
      A2:      if (fetch_en) dbus = pc[7:4];
      A3:      if (fetch_en) dbus = pc[11:8];
      X2:      if (bus.x2_oe) dbus = bus.x2_data;
      default: dbus = DBUS_IDLE;
    endcase
  end

  assign bus.dbus_out    = dbus;
  assign bus.cm_rom      = fetch_en && ((phase == M2 && state == WORD1 && opr_q == 4'hE) ||
                                        (phase == X2 && bus.x2_cm));
  assign bus.sync        = (phase == X3);
  assign bus.icyc        = phase;
  assign bus.fetch_state = (state == WORD2);
  assign bus.instr_valid = instr_valid;
  assign bus.instr_opr   = instr_opr;
  assign bus.instr_opa   = instr_opa;
  assign bus.instr_word2 = instr_word2;
  assign bus.instr_two   = instr_two;
  assign bus.instr_pc    = instr_pc;
endmodule

// File: tb/tb_i4004_fetch.sv
// Bench for i4004_fetch: ROM responder, per-phase reference model with instruction scoreboard,
// and directed fetch scenarios (breakpoint scenario only when MCS4_FETCH_BKPT_EN is defined).
module tb_i4004_fetch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i4004_fetch_if bus();
  i4004_fetch #(.RESET_PC(12'h000), .DBUS_IDLE(4'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0]  rom [0:4095];
  logic [11:0] rom_addr;
  int          checks = 0;
  int          errors = 0;
  logic [28:0] exp_q[$];

  // ROM: latches the address nibbles like an i4001, drives OPR at M1 and OPA at M2.
  always @(posedge clk) begin
    if (bus.icyc == 3'd0) rom_addr[3:0]  <= bus.dbus_out;
    if (bus.icyc == 3'd1) rom_addr[7:4]  <= bus.dbus_out;
    if (bus.icyc == 3'd2) rom_addr[11:8] <= bus.dbus_out;
  end
  assign bus.dbus_in = (bus.icyc == 3'd3) ? rom[rom_addr][7:4] :
                       (bus.icyc == 3'd4) ? rom[rom_addr][3:0] : 4'h9;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic two_word(input logic [7:0] w);
    return (w[7:4] == 4'h1) || (w[7:4] == 4'h2 && !w[0]) || (w[7:4] == 4'h4) ||
           (w[7:4] == 4'h5) || (w[7:4] == 4'h7);
  endfunction

  // Reference model: one step per bus phase, expectations derived from phase number and ROM.
  int          mp;
  logic        m_on = 1'b0;
  logic [11:0] mpc, m_w1pc, e_pc;
  logic [7:0]  m_w1, e_w2;
  logic [3:0]  e_opr, e_opa;
  logic        m_pend, m_boot, m_halt, m_res, e_two;

  task automatic model_compare();
    logic        fire, e_cm;
    logic [7:0]  w;
    logic [3:0]  e_dbus;
    logic [28:0] got;
    fire = 1'b0;
    if (mp == 5 && !m_halt) begin
      w = rom[mpc];
      if (m_pend) begin
        fire = 1'b1;
        m_pend = 1'b0;
        {e_pc, e_opr, e_opa, e_w2, e_two} = {m_w1pc, m_w1, w, 1'b1};
      end else if (two_word(w)) begin
        m_pend = 1'b1;
        m_w1   = w;
        m_w1pc = mpc;
      end else begin
        fire = 1'b1;
        {e_pc, e_opr, e_opa, e_w2, e_two} = {mpc, w, 8'h00, 1'b0};
      end
      if (fire) exp_q.push_back({e_pc, e_opr, e_opa, e_w2, e_two});
    end
    e_dbus = 4'h0;
    if (!m_halt && mp <= 2) e_dbus = mpc[mp*4 +: 4];
    if (mp == 6 && bus.x2_oe) e_dbus = bus.x2_data;
    e_cm = !m_halt && ((mp == 4 && !m_pend && rom[mpc][7:4] == 4'hE) || (mp == 6 && bus.x2_cm));
    chk("icyc", 32'(bus.icyc), 32'(mp));
    chk("sync", 32'(bus.sync), 32'(mp == 7));
    chk("dbus_out", 32'(bus.dbus_out), 32'(e_dbus));
    chk("cm_rom", 32'(bus.cm_rom), 32'(e_cm));
    chk("instr_valid", 32'(bus.instr_valid), 32'(fire));
    chk("instr_fields", {bus.instr_pc, bus.instr_opr, bus.instr_opa, bus.instr_word2, bus.instr_two},
        32'({e_pc, e_opr, e_opa, e_w2, e_two}));
`ifdef MCS4_FETCH_BKPT_EN
    chk("bkpt_hit", 32'(bus.bkpt_hit), 32'(m_halt));
`endif
    if (bus.instr_valid) begin
      got = {bus.instr_pc, bus.instr_opr, bus.instr_opa, bus.instr_word2, bus.instr_two};
      if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'(got), 32'h0);
      else chk("sb_instr", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic model_advance();
    logic [11:0] nxt;
`ifdef MCS4_FETCH_BKPT_EN
    if (m_halt && bus.bkpt_resume) m_res = 1'b1;
`endif
    if (mp == 7) begin
      if (m_boot) m_boot = 1'b0;
      else if (m_halt) begin
        if (m_res) begin
          m_halt = 1'b0;
          m_res  = 1'b0;
        end
      end else begin
        nxt = bus.jmp_valid ? bus.jmp_addr : mpc + 12'd1;
        if (bus.jmp_valid) m_pend = 1'b0;
        mpc = nxt;
`ifdef MCS4_FETCH_BKPT_EN
        if (bus.bkpt_en && nxt == bus.bkpt_addr) m_halt = 1'b1;
`endif
      end
    end
    mp = (mp + 1) % 8;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_on) model_compare();
      if (!rst_n) begin
        mp = 7; mpc = 12'h000; m_pend = 1'b0; m_boot = 1'b1; m_halt = 1'b0; m_res = 1'b0;
        {e_pc, e_opr, e_opa, e_w2, e_two} = '0;
        exp_q.delete();
        m_on = 1'b1;
      end else if (m_on) begin
        model_advance();
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int p);
    int n = 0;
    while (32'(bus.icyc) != p && n < 16) begin
      step();
      n++;
    end
    if (n >= 16) chk("goto_timeout", 32'(bus.icyc), 32'(p));
  endtask

  task automatic goto_next(input int p);
    step();
    goto(p);
  endtask

  task automatic jump_to(input logic [11:0] a);
    goto(7);
    bus.jmp_valid = 1'b1;
    bus.jmp_addr  = a;
    step();
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = 12'h5A5;
  endtask

  task automatic chk_addr(input string nm, input logic [3:0] n0, input logic [3:0] n1,
                          input logic [3:0] n2);
    chk({nm, "_a1"}, 32'(bus.dbus_out), 32'(n0));
    step();
    chk({nm, "_a2"}, 32'(bus.dbus_out), 32'(n1));
    step();
    chk({nm, "_a3"}, 32'(bus.dbus_out), 32'(n2));
  endtask

  task automatic chk_instr(input string nm, input logic [3:0] opr, input logic [3:0] opa,
                           input logic [7:0] w2, input logic two, input logic [11:0] pc);
    chk({nm, "_valid"}, 32'(bus.instr_valid), 32'h1);
    chk({nm, "_fields"}, {bus.instr_pc, bus.instr_opr, bus.instr_opa, bus.instr_word2, bus.instr_two},
        32'({pc, opr, opa, w2, two}));
  endtask

  // Watchdog keeps the run bounded even if the bench logic itself stalls.
  initial begin
    #200000;
    chk("watchdog", 32'h1, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] table_words [16] = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h44, 8'h40, 8'h12, 8'h50,
                                   8'hE1, 8'h70, 8'hE4, 8'hD5, 8'h30, 8'hF0, 8'h28, 8'h81};

  initial begin
    rst_n = 1'b0;
    bus.x2_oe = 1'b0; bus.x2_data = 4'h0; bus.x2_cm = 1'b0;
    bus.jmp_valid = 1'b0; bus.jmp_addr = 12'h000;
`ifdef MCS4_FETCH_BKPT_EN
    bus.bkpt_en = 1'b0; bus.bkpt_addr = 12'h000; bus.bkpt_resume = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h99;
    rom[12'h123] = 8'hDA;
    rom[12'h010] = 8'h40; rom[12'h011] = 8'h56;
    rom[12'h020] = 8'h22; rom[12'h021] = 8'h33;
    rom[12'h040] = 8'hE2; rom[12'h041] = 8'h50; rom[12'h042] = 8'hE0;
    rom[12'hFFF] = 8'hD1;
    for (int i = 0; i < 16; i++) rom[12'h100 + 12'(i)] = table_words[i];

    // Reset state, then the first A1..A3 carry pc=0
    step(); step();
    chk("rst_sync", 32'(bus.sync), 32'h1);
    chk("rst_icyc", 32'(bus.icyc), 32'h7);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_cm", 32'(bus.cm_rom), 32'h0);
    rst_n = 1'b1;
    step();
    chk("t1_icyc", 32'(bus.icyc), 32'h0);
    chk_addr("t1", 4'h0, 4'h0, 4'h0);
    chk("t1_sync_a3", 32'(bus.sync), 32'h0);

    // One-word fetch at 0x123; a jmp_valid outside X3 must be ignored
    jump_to(12'h123);
    chk_addr("t2", 4'h3, 4'h2, 4'h1);
    step();
    bus.jmp_valid = 1'b1; bus.jmp_addr = 12'h777;
    step();
    bus.jmp_valid = 1'b0;
    step();
    chk_instr("t2", 4'hD, 4'hA, 8'h00, 1'b0, 12'h123);
    goto(0);
    chk_addr("t2_next", 4'h4, 4'h2, 4'h1);

    // Two-word JUN at 0x010
    jump_to(12'h010);
    goto(5);
    chk("t3_word1_valid", 32'(bus.instr_valid), 32'h0);
    goto_next(5);
    chk_instr("t3", 4'h4, 4'h0, 8'h56, 1'b1, 12'h010);

    // Redirect between the two words of FIM drops the pending word
    jump_to(12'h020);
    goto(5);
    chk("t4_word1_valid", 32'(bus.instr_valid), 32'h0);
    jump_to(12'hABC);
    chk_addr("t4", 4'hC, 4'hB, 4'hA);
    goto(5);
    chk_instr("t4", 4'h0, 4'h0, 8'h00, 1'b0, 12'hABC);

    // I/O group command line and X2 drive; then JMS whose second word starts with E
    jump_to(12'h040);
    goto(3);
    chk("t5_cm_m1", 32'(bus.cm_rom), 32'h0);
    step();
    chk("t5_cm_m2", 32'(bus.cm_rom), 32'h1);
    step();
    bus.x2_oe = 1'b1; bus.x2_data = 4'h7; bus.x2_cm = 1'b1;
    step();
    chk("t5_x2_dbus", 32'(bus.dbus_out), 32'h7);
    chk("t5_x2_cm", 32'(bus.cm_rom), 32'h1);
    bus.x2_oe = 1'b0; bus.x2_cm = 1'b0;
    step();
    chk("t5_cm_x3", 32'(bus.cm_rom), 32'h0);
    goto(4);
    goto_next(4);
    chk("t5_cm_word2", 32'(bus.cm_rom), 32'h0);
    goto(5);
    chk_instr("t5", 4'h5, 4'h0, 8'hE0, 1'b1, 12'h041);

    // PC wrap, then a two-word instruction straddling the wrap
    jump_to(12'hFFF);
    goto(5);
    chk_instr("t6", 4'hD, 4'h1, 8'h00, 1'b0, 12'hFFF);
    goto(0);
    chk_addr("t6_wrap", 4'h0, 4'h0, 4'h0);
    rom[12'hFFF] = 8'h71;
    jump_to(12'hFFF);
    goto(5);
    chk("t6_straddle_w1", 32'(bus.instr_valid), 32'h0);
    goto_next(5);
    chk_instr("t6_straddle", 4'h7, 4'h1, 8'h99, 1'b1, 12'hFFF);
    rom[12'hFFF] = 8'hD1;

    // Reset in the middle of the second word of JUN
    jump_to(12'h010);
    goto(5);
    goto(3);
    rst_n = 1'b0;
    step();
    chk("t7_rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("t7_rst_pc", 32'(bus.instr_pc), 32'h0);
    rst_n = 1'b1;
    step();
    goto(5);
    chk_instr("t7", 4'h9, 4'h9, 8'h00, 1'b0, 12'h000);

    // Mixed opcode table with X2 traffic and occasional redirects
    jump_to(12'h100);
    for (int i = 0; i < 200; i++) begin
      bus.x2_oe     = (i % 3 == 0);
      bus.x2_cm     = (i % 5 == 0);
      bus.x2_data   = 4'(i);
      bus.jmp_valid = (i % 37 == 0);
      bus.jmp_addr  = 12'h100 + 12'(i % 16);
      step();
    end
    bus.x2_oe = 1'b0; bus.x2_cm = 1'b0; bus.jmp_valid = 1'b0;

`ifdef MCS4_FETCH_BKPT_EN
    // Breakpoint on the wrapped address, then resume
    bus.bkpt_en = 1'b1; bus.bkpt_addr = 12'h000;
    jump_to(12'hFFF);
    goto(7);
    step();
    chk("t8_hit", 32'(bus.bkpt_hit), 32'h1);
    chk("t8_idle_a1", 32'(bus.dbus_out), 32'h0);
    for (int i = 0; i < 16; i++) step();
    goto(5);
    chk("t8_halt_valid", 32'(bus.instr_valid), 32'h0);
    step();
    bus.bkpt_resume = 1'b1;
    step();
    bus.bkpt_resume = 1'b0;
    goto(7);
    step();
    chk("t8_resumed", 32'(bus.bkpt_hit), 32'h0);
    goto(5);
    chk_instr("t8", 4'h9, 4'h9, 8'h00, 1'b0, 12'h000);
    bus.bkpt_en = 1'b0;
`endif

    for (int i = 0; i < 8; i++) step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
